// File: rtl/imem_boot_loader.sv
// Byte-stream instruction loader: takes a length-prefixed little-endian image,
// writes it to instruction memory from word 0, and holds the core in reset until done.
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);
  typedef enum logic [2:0] {HDR0, HDR1, DATA, FLUSH, DONE} state_e;

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic [15:0]         n_q, n_d;
  logic [15:0]         widx_q, widx_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [23:0]         asm_q, asm_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [15:0]         wl_q, wl_d;
  logic                xfer;
  logic                ovf;

  // in_ready is gated by rst_n so it reads 0 while reset is held
  assign in_ready = rst_n && (state_q == HDR0 || state_q == HDR1 || state_q == DATA);
  assign xfer     = in_valid && in_ready;
  assign ovf      = {1'b0, widx_q} >= DEPTH;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    wl_d    = wl_q;
    case (state_q)
      HDR0: if (xfer) begin
        n_d[7:0] = in_data;
        state_d  = HDR1;
      end
      HDR1: if (xfer) begin
        n_d[15:8] = in_data;
        widx_d    = '0;
        bidx_d    = '0;
        state_d   = ({in_data, n_q[7:0]} == 16'd0) ? FLUSH : DATA;
      end
      DATA: if (xfer) begin
        bidx_d = bidx_q + 2'd1;
        case (bidx_q)
          2'd0: asm_d[7:0]   = in_data;
          2'd1: asm_d[15:8]  = in_data;
          2'd2: asm_d[23:16] = in_data;
          default: begin
            // Word complete: out-of-range slots still advance the index so
            // the stream stays aligned, but never touch memory.
            if (ovf) begin
              err_d = 1'b1;
            end else begin
              we_d    = 1'b1;
              addr_d  = widx_q[ADDR_W-1:0];
              wdata_d = {in_data, asm_q};
              wl_d    = wl_q + 16'd1;
            end
            widx_d = widx_q + 16'd1;
            if (widx_q == n_q - 16'd1) state_d = FLUSH;
          end
        endcase
      end
      FLUSH:   state_d = DONE;
      default: state_d = DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HDR0;
      n_q     <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      wl_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      wl_q    <= wl_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign done         = (state_q == DONE);
  assign core_rst_n   = (state_q == DONE);
  assign err          = err_q;
  assign words_loaded = wl_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench: one loader with full-size memory and one with a 4-word memory
// share the same byte stream; the small one exercises the overflow path.
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;

  logic        rdy_a, we_a, crst_a, done_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wd_a;
  logic [15:0] wl_a;
  logic        rdy_b, we_b, crst_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wd_b;
  logic [15:0] wl_b;

  imem_boot_loader #(.ADDR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
    .core_rst_n(crst_a), .done(done_a), .err(err_a), .words_loaded(wl_a));

  imem_boot_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b),
    .core_rst_n(crst_b), .done(done_b), .err(err_b), .words_loaded(wl_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int acc[$];
  int qa_cyc[$];
  logic [7:0]  qa_addr[$];
  logic [31:0] qa_data[$];
  logic [1:0]  qb_addr[$];
  logic [31:0] qb_data[$];
  logic loading = 1'b0;
  int   ready_drops = 0;

  always @(negedge clk) begin
    if (rst_n && we_a) begin
      qa_addr.push_back(addr_a); qa_data.push_back(wd_a); qa_cyc.push_back(cyc);
    end
    if (rst_n && we_b) begin
      qb_addr.push_back(addr_b); qb_data.push_back(wd_b);
    end
    if (loading && !rdy_a) ready_drops++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    qa_addr.delete(); qa_data.delete(); qa_cyc.delete();
    qb_addr.delete(); qb_data.delete(); acc.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int k;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_data = b;
    k = 0;
    while (!rdy_a && k < 16) begin @(negedge clk); k++; end
    if (!rdy_a) begin
      chk("accept_timeout", {31'd0, rdy_a}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc.push_back(cyc);
  endtask

  logic [7:0] img_basic[10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] img_rst1[7]   = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] img_rst2[6]   = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20};

  initial begin
    int nq, wl0;
    // Reset values while rst_n is held low
    #12;
    chk("rst_in_ready", {31'd0, rdy_a}, 32'd0);
    chk("rst_we", {31'd0, we_a}, 32'd0);
    chk("rst_addr", {24'd0, addr_a}, 32'd0);
    chk("rst_wdata", wd_a, 32'd0);
    chk("rst_core_rst_n", {31'd0, crst_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    chk("rst_words", {16'd0, wl_a}, 32'd0);

    // Basic full-rate load
    do_reset();
    @(negedge clk);
    chk("hdr0_ready", {31'd0, rdy_a}, 32'd1);
    for (int i = 0; i < 10; i++) send(img_basic[i], 0);
    @(negedge clk);
    chk("basic_flush_we", {31'd0, we_a}, 32'd1);
    chk("basic_flush_done", {31'd0, done_a}, 32'd0);
    chk("basic_flush_ready", {31'd0, rdy_a}, 32'd0);
    @(negedge clk);
    chk("basic_done", {31'd0, done_a}, 32'd1);
    chk("basic_core_rst_n", {31'd0, crst_a}, 32'd1);
    chk("basic_nwrites", qa_addr.size(), 32'd2);
    if (qa_addr.size() == 2) begin
      chk("basic_a0", {24'd0, qa_addr[0]}, 32'd0);
      chk("basic_d0", qa_data[0], 32'h12345678);
      chk("basic_t0", qa_cyc[0], acc[5]);
      chk("basic_a1", {24'd0, qa_addr[1]}, 32'd1);
      chk("basic_d1", qa_data[1], 32'hDEADBEEF);
      chk("basic_t1", qa_cyc[1], acc[9]);
    end
    chk("basic_words", {16'd0, wl_a}, 32'd2);
    chk("basic_err", {31'd0, err_a}, 32'd0);

    // Throttled source
    do_reset();
    loading = 1'b1;
    for (int i = 0; i < 10; i++) send(img_basic[i], $urandom_range(0, 3));
    loading = 1'b0;
    repeat (2) @(negedge clk);
    chk("thr_ready_drops", ready_drops, 32'd0);
    chk("thr_nwrites", qa_addr.size(), 32'd2);
    if (qa_addr.size() == 2) begin
      chk("thr_d0", qa_data[0], 32'h12345678);
      chk("thr_a1", {24'd0, qa_addr[1]}, 32'd1);
      chk("thr_d1", qa_data[1], 32'hDEADBEEF);
    end
    chk("thr_done", {31'd0, done_a}, 32'd1);

    // Post-done: offered bytes are refused and nothing moves
    nq = qa_addr.size(); wl0 = wl_a;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_ready", {31'd0, rdy_a}, 32'd0);
    end
    in_valid = 1'b0;
    chk("post_nwrites", qa_addr.size(), nq);
    chk("post_words", {16'd0, wl_a}, wl0);
    chk("post_addr", {24'd0, addr_a}, 32'd1);
    chk("post_wdata", wd_a, 32'hDEADBEEF);
    chk("post_done", {31'd0, done_a}, 32'd1);

    // Empty image
    do_reset();
    send(8'h00, 0); send(8'h00, 0);
    @(negedge clk);
    chk("empty_flush_done", {31'd0, done_a}, 32'd0);
    @(negedge clk);
    chk("empty_done", {31'd0, done_a}, 32'd1);
    chk("empty_nwrites", qa_addr.size(), 32'd0);
    chk("empty_words", {16'd0, wl_a}, 32'd0);

    // Overflow: the 4-word instance drops the 5th word
    do_reset();
    send(8'h05, 0); send(8'h00, 0);
    for (int w = 1; w <= 5; w++)
      for (int j = 0; j < 4; j++)
        if (!(w == 5 && j == 3)) send((j == 0) ? 8'(w) : 8'h00, 0);
    @(negedge clk);
    chk("ovf_err_before", {31'd0, err_b}, 32'd0);
    send(8'h00, 0);
    @(negedge clk);
    chk("ovf_err_set", {31'd0, err_b}, 32'd1);
    chk("ovf_we_suppr", {31'd0, we_b}, 32'd0);
    chk("ovf_bigmem_we", {31'd0, we_a}, 32'd1);
    @(negedge clk);
    chk("ovf_accepted", acc.size(), 32'd22);
    chk("ovf_nwrites", qb_addr.size(), 32'd4);
    for (int i = 0; i < qb_addr.size() && i < 4; i++) begin
      chk("ovf_addr", {30'd0, qb_addr[i]}, i);
      chk("ovf_data", qb_data[i], i + 1);
    end
    chk("ovf_words", {16'd0, wl_b}, 32'd4);
    chk("ovf_done", {31'd0, done_b}, 32'd1);
    chk("ovf_bigmem_words", {16'd0, wl_a}, 32'd5);
    chk("ovf_bigmem_err", {31'd0, err_a}, 32'd0);

    // Reset mid-load, then a fresh image
    do_reset();
    for (int i = 0; i < 7; i++) send(img_rst1[i], 0);
    chk("mid_words_pre", {16'd0, wl_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, rdy_a}, 32'd0);
    chk("mid_rst_words", {16'd0, wl_a}, 32'd0);
    chk("mid_rst_addr", {24'd0, addr_a}, 32'd0);
    chk("mid_rst_wdata", wd_a, 32'd0);
    chk("mid_rst_core", {31'd0, crst_a}, 32'd0);
    do_reset();
    for (int i = 0; i < 6; i++) send(img_rst2[i], 0);
    repeat (2) @(negedge clk);
    chk("mid_nwrites", qa_addr.size(), 32'd1);
    if (qa_addr.size() == 1) begin
      chk("mid_addr", {24'd0, qa_addr[0]}, 32'd0);
      chk("mid_data", qa_data[0], 32'h20000000);
    end
    chk("mid_words", {16'd0, wl_a}, 32'd1);
    chk("mid_done", {31'd0, done_a}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
